// File: rtl/nios_security_pio_pkg.sv
// Shared register map, CTRL bit positions and watchdog state encoding for the
// security-subsystem Avalon PIO ports.
package nios_security_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_OUTSET   = 2'd1;
    localparam logic [1:0] ADDR_OUTCLEAR = 2'd2;
    localparam logic [1:0] ADDR_CTRL     = 2'd3;

    localparam int CTRL_WDOG_EN = 0;
    localparam int CTRL_TRIPPED = 1;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        TRIPPED  = 2'd2
    } wdog_state_e;

endpackage

// File: rtl/nios_security_wdog_counter.sv
// Loadable down-counter for the refresh watchdog; reloads to TIMEOUT_CYCLES-1
// and saturates at zero.
module nios_security_wdog_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int unsigned     CNT_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/nios_security_motor_out.sv
// Avalon-MM motor-command output port with atomic set/clear and a refresh
// watchdog that forces out_port to SAFE_VALUE when software goes quiet.
module nios_security_motor_out
    import nios_security_pio_pkg::*;
#(
    parameter int unsigned       WIDTH          = 16,
    parameter logic [WIDTH-1:0]  RESET_VALUE    = '0,
    parameter logic [WIDTH-1:0]  SAFE_VALUE     = '0,
    parameter int unsigned       TIMEOUT_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             wdog_en_q, wdog_en_d;
    wdog_state_e      state_q, state_d;
    logic [WIDTH-1:0] out_port_q, out_port_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             wr, ctrl_wr, refresh;
    logic             cnt_load, cnt_en, cnt_zero;
    logic             unused_wdata;

    assign wr           = chipselect && !write_n;
    assign ctrl_wr      = wr && (address == ADDR_CTRL);
    assign refresh      = wr && (address != ADDR_CTRL);
    assign unused_wdata = ^writedata;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        data_d = data_q;
        if (wr) begin
            case (address)
                ADDR_DATA:     data_d = writedata[WIDTH-1:0];
                ADDR_OUTSET:   data_d = data_q | writedata[WIDTH-1:0];
                ADDR_OUTCLEAR: data_d = data_q & ~writedata[WIDTH-1:0];
                default:       data_d = data_q;
            endcase
        end

        wdog_en_d = ctrl_wr ? writedata[CTRL_WDOG_EN] : wdog_en_q;

        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            DISARMED: begin
                cnt_load = 1'b1;
                if (wdog_en_d) state_d = ARMED;
            end
            ARMED: begin
                if (!wdog_en_d) begin
                    state_d  = DISARMED;
                    cnt_load = 1'b1;
                end else if (refresh) begin
                    cnt_load = 1'b1;
                end else if (cnt_zero) begin
                    state_d = TRIPPED;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            TRIPPED: begin
                // Data writes are not a way out; only an explicit W1C of TRIPPED.
                if (ctrl_wr && writedata[CTRL_TRIPPED]) begin
                    state_d  = wdog_en_d ? ARMED : DISARMED;
                    cnt_load = 1'b1;
                end
            end
            default: begin
                state_d  = DISARMED;
                cnt_load = 1'b1;
            end
        endcase

        out_port_d = (state_d == TRIPPED) ? SAFE_VALUE : data_d;

        readdata_d = '0;
        case (address)
            ADDR_DATA: readdata_d[WIDTH-1:0] = data_q;
            ADDR_CTRL: begin
                readdata_d[CTRL_WDOG_EN] = wdog_en_q;
                readdata_d[CTRL_TRIPPED] = (state_q == TRIPPED);
            end
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            wdog_en_q  <= 1'b0;
            state_q    <= DISARMED;
            out_port_q <= RESET_VALUE;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            wdog_en_q  <= wdog_en_d;
            state_q    <= state_d;
            out_port_q <= out_port_d;
            readdata_q <= readdata_d;
        end
    end

    nios_security_wdog_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (cnt_load),
        .en      (cnt_en),
        .zero    (cnt_zero)
    );

    assign out_port = out_port_q;
    assign readdata = readdata_q;

endmodule
